// File: rtl/gcd_requester.sv
// Sequences one operand pair at a time through an external GCD engine and returns the result downstream.
// Optional WAIT timeout abort is compiled in when the GCD_TIMEOUT_EN macro is defined.
module gcd_requester #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gcd_a_q, gcd_a_d;
  logic [WIDTH-1:0] gcd_b_q, gcd_b_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
  logic             out_err_q, out_err_d;

`ifdef GCD_TIMEOUT_EN
  // Counter only has to reach TIMEOUT-1, the value of the last WAIT cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d   = state_q;
    gcd_a_d   = gcd_a_q;
    gcd_b_d   = gcd_b_q;
    out_gcd_d = out_gcd_q;
    out_err_d = out_err_q;
`ifdef GCD_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((in_a != '0) && (in_b != '0)) begin
            gcd_a_d = in_a;
            gcd_b_d = in_b;
            state_d = START;
          end else begin
            // A zero operand makes the answer the other operand; both zero is an error.
            out_gcd_d = in_a | in_b;
            out_err_d = (in_a == '0) && (in_b == '0);
            state_d   = RESP;
          end
        end
      end
      START: begin
        state_d = WAIT;
`ifdef GCD_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (gcd_done) begin
          out_gcd_d = gcd_result;
          out_err_d = 1'b0;
          state_d   = RESP;
        end
`ifdef GCD_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          out_gcd_d = '0;
          out_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gcd_a_q   <= '0;
      gcd_b_q   <= '0;
      out_gcd_q <= '0;
      out_err_q <= 1'b0;
`ifdef GCD_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gcd_a_q   <= gcd_a_d;
      gcd_b_q   <= gcd_b_d;
      out_gcd_q <= out_gcd_d;
      out_err_q <= out_err_d;
`ifdef GCD_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // State already reads IDLE during reset, so in_ready is gated to stay low there.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign gcd_start = (state_q == START);
  assign out_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign out_gcd   = out_gcd_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed self-checking bench for gcd_requester; engine responses are driven by hand in the sequence.
module tb_gcd_requester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       gcd_start;
  logic [7:0] gcd_a;
  logic [7:0] gcd_b;
  logic       gcd_done;
  logic [7:0] gcd_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_gcd;
  logic       out_err;
  logic       busy;

  int errors    = 0;
  int checks    = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  gcd_requester #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (gcd_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit stable;
    bit hold;
    int wait_cycles;
    int n;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    gcd_done = 1'b0; gcd_result = '0; out_ready = 1'b0;
    cyc(2);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_gcd_start", 32'(gcd_start), 0);
    chk("rst_gcd_a", 32'(gcd_a), 0);
    chk("rst_gcd_b", 32'(gcd_b), 0);
    chk("rst_out_gcd", 32'(out_gcd), 0);
    chk("rst_out_err", 32'(out_err), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    cyc(1);

    // gcd_done while idle must not wake the block
    gcd_done = 1'b1; gcd_result = 8'd99;
    cyc(1);
    gcd_done = 1'b0;
    chk("idle_done_busy", 32'(busy), 0);
    chk("idle_done_valid", 32'(out_valid), 0);

    // (48,18) -> 6, with a stray gcd_done during START
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    cyc(1);
    in_valid = 1'b0;
    chk("t1_start", 32'(gcd_start), 1);
    chk("t1_gcd_a", 32'(gcd_a), 48);
    chk("t1_gcd_b", 32'(gcd_b), 18);
    chk("t1_in_ready", 32'(in_ready), 0);
    chk("t1_busy", 32'(busy), 1);
    gcd_done = 1'b1; gcd_result = 8'd99;
    cyc(1);
    gcd_done = 1'b0;
    chk("t1_start_once", 32'(gcd_start), 0);
    chk("t1_done_in_start_ignored", 32'(out_valid), 0);
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (gcd_a !== 8'd48 || gcd_b !== 8'd18 || gcd_start !== 1'b0 || out_valid !== 1'b0) stable = 1'b0;
      cyc(1);
    end
    gcd_done = 1'b1; gcd_result = 8'd6;
    cyc(1);
    gcd_done = 1'b0; gcd_result = 8'd0;
    chk("t1_operands_stable", 32'(stable), 1);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_gcd", 32'(out_gcd), 6);
    chk("t1_out_err", 32'(out_err), 0);
    chk("t1_start_count", 32'(start_cnt), 1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("t1_valid_drop", 32'(out_valid), 0);
    chk("t1_in_ready_back", 32'(in_ready), 1);
    $display("txn (48,18) -> gcd=%0d err=%0d", 6, 0);

    // (0,7) bypass
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd7;
    cyc(1);
    in_valid = 1'b0;
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_out_gcd", 32'(out_gcd), 7);
    chk("t2_out_err", 32'(out_err), 0);
    chk("t2_no_start", 32'(start_cnt), 1);
    out_ready = 1'b1;
    cyc(1);
    chk("t2_valid_drop", 32'(out_valid), 0);
    chk("t2_in_ready_back", 32'(in_ready), 1);
    $display("txn (0,7) -> gcd=%0d err=%0d", 7, 0);

    // (0,0) back-to-back, straight after the previous handshake
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd0;
    cyc(1);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3_out_valid", 32'(out_valid), 1);
    chk("t3_out_gcd", 32'(out_gcd), 0);
    chk("t3_out_err", 32'(out_err), 1);
    chk("t3_no_start", 32'(start_cnt), 1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("t3_valid_drop", 32'(out_valid), 0);
    $display("txn (0,0) -> gcd=%0d err=%0d", 0, 1);

    // result held under back-pressure while in_valid pulses are ignored
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    cyc(1);
    in_valid = 1'b0;
    cyc(3);
    gcd_done = 1'b1; gcd_result = 8'd6;
    cyc(1);
    gcd_done = 1'b0; gcd_result = 8'd0;
    chk("t4_out_valid", 32'(out_valid), 1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_gcd !== 8'd6 || out_err !== 1'b0 || in_ready !== 1'b0) hold = 1'b0;
      in_valid = (i % 2 == 0); in_a = 8'd5; in_b = 8'd10;
      cyc(1);
    end
    in_valid = 1'b0;
    chk("t4_held", 32'(hold), 1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("t4_valid_drop", 32'(out_valid), 0);
    chk("t4_in_ready_back", 32'(in_ready), 1);
    chk("t4_no_capture", 32'(gcd_a), 48);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_start_count", 32'(start_cnt), 2);
    $display("txn (48,18) backpressured -> gcd=%0d err=%0d", 6, 0);

    // reset in the middle of WAIT, then a fresh (35,21)
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    cyc(1);
    in_valid = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_in_ready", 32'(in_ready), 0);
    chk("t5_rst_gcd_a", 32'(gcd_a), 0);
    chk("t5_rst_gcd_b", 32'(gcd_b), 0);
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_rel_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_a = 8'd35; in_b = 8'd21;
    cyc(1);
    in_valid = 1'b0;
    chk("t5_gcd_a", 32'(gcd_a), 35);
    cyc(3);
    gcd_done = 1'b1; gcd_result = 8'd7;
    cyc(1);
    gcd_done = 1'b0; gcd_result = 8'd0;
    chk("t5_out_valid", 32'(out_valid), 1);
    chk("t5_out_gcd", 32'(out_gcd), 7);
    chk("t5_out_err", 32'(out_err), 0);
    chk("t5_start_count", 32'(start_cnt), 4);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    $display("txn (35,21) after reset -> gcd=%0d err=%0d", 7, 0);

`ifdef GCD_TIMEOUT_EN
    // engine never answers: abort after 16 WAIT cycles
    in_valid = 1'b1; in_a = 8'd12; in_b = 8'd8;
    cyc(1);
    in_valid = 1'b0;
    wait_cycles = 0; n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      if (busy === 1'b1 && gcd_start === 1'b0) wait_cycles++;
      cyc(1);
      n++;
    end
    chk("t6_timeout_valid", 32'(out_valid), 1);
    chk("t6_wait_cycles", 32'(wait_cycles), 16);
    chk("t6_out_gcd", 32'(out_gcd), 0);
    chk("t6_out_err", 32'(out_err), 1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    $display("txn (12,8) timeout -> gcd=%0d err=%0d", 0, 1);

    // gcd_done on the expiry edge wins over the timeout
    in_valid = 1'b1; in_a = 8'd12; in_b = 8'd8;
    cyc(1);
    in_valid = 1'b0;
    cyc(16);
    gcd_done = 1'b1; gcd_result = 8'd4;
    cyc(1);
    gcd_done = 1'b0; gcd_result = 8'd0;
    chk("t7_out_valid", 32'(out_valid), 1);
    chk("t7_out_gcd", 32'(out_gcd), 4);
    chk("t7_out_err", 32'(out_err), 0);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    $display("txn (12,8) done at expiry -> gcd=%0d err=%0d", 4, 0);
`else
    // without the timeout, WAIT persists until the engine answers
    in_valid = 1'b1; in_a = 8'd12; in_b = 8'd8;
    cyc(1);
    in_valid = 1'b0;
    wait_cycles = 0; n = 0;
    cyc(40);
    chk("t6_still_waiting", 32'(out_valid), 0);
    chk("t6_still_busy", 32'(busy), 1);
    gcd_done = 1'b1; gcd_result = 8'd4;
    cyc(1);
    gcd_done = 1'b0; gcd_result = 8'd0;
    chk("t6_out_valid", 32'(out_valid), 1);
    chk("t6_out_gcd", 32'(out_gcd), 4);
    chk("t6_out_err", 32'(out_err), 0);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    $display("txn (12,8) slow engine -> gcd=%0d err=%0d", 4, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort (used only with GCD_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_a input WIDTH, in_b input WIDTH: upstream operand-pair handshake.
REQ-006 SHALL have ports gcd_start output 1, gcd_a output WIDTH, gcd_b output WIDTH: request to GCD engine.
REQ-007 SHALL have ports gcd_done input 1, gcd_result input WIDTH: completion from GCD engine.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_gcd output WIDTH, out_err output 1: downstream result handshake.
REQ-009 SHALL have port busy  output 1  high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, START, WAIT, RESP.
REQ-011 in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-012 On transfer with in_a!=0 and in_b!=0: capture operands into gcd_a/gcd_b, next state START.
REQ-013 On transfer with in_a==0 or in_b==0 (bypass): out_gcd=in_a|in_b, out_err=(in_a==0 && in_b==0), next state RESP; gcd_start never pulses.
REQ-014 START: gcd_start=1 for exactly one cycle, next state WAIT unconditionally; gcd_done ignored in START.
REQ-015 gcd_a/gcd_b SHALL be held stable from START until exit from WAIT.
REQ-016 WAIT: on edge with gcd_done=1, capture gcd_result into out_gcd, out_err=0, next state RESP.
REQ-017 gcd_done outside WAIT SHALL have no effect.
REQ-018 RESP: out_valid=1; out_gcd and out_err SHALL be held stable until out_valid&out_ready; on that edge, next state IDLE and out_valid=0 the following cycle.
REQ-019 Latency: gcd_start high in the cycle after transfer; out_valid high in the cycle after gcd_done sampled; bypass out_valid high in the cycle after transfer.
REQ-020 in_valid during busy SHALL be ignored and no operands captured (back-pressure via in_ready=0).
REQ-021 Back-to-back: a new transfer is possible in the cycle after the RESP handshake edge.

Reset
REQ-022 While rst_n=0: state IDLE; in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_gcd, out_err, busy all 0; timeout counter 0.
REQ-023 Reset assertion at any point (including mid-WAIT) SHALL abort the transaction immediately; first cycle after deassertion in_ready=1.

Configuration
REQ-024 Macro GCD_TIMEOUT_EN defined: a counter clears on WAIT entry and increments each WAIT cycle; if TIMEOUT cycles elapse without gcd_done, next state RESP with out_gcd=0, out_err=1; gcd_done on the same edge as expiry takes priority (normal result).
REQ-025 Macro GCD_TIMEOUT_EN undefined: no counter; WAIT persists until gcd_done; out_err set only per REQ-013.

Verification
REQ-026 Operands (48,18), engine model asserts done 10 cycles after start with result 6 -> single gcd_start pulse, gcd_a=48/gcd_b=18 stable, out_gcd=6, out_err=0.
REQ-027 Operands (0,7) -> no gcd_start, out_valid the cycle after transfer, out_gcd=7, out_err=0.
REQ-028 Operands (0,0) -> out_gcd=0, out_err=1, no gcd_start.
REQ-029 Result 6 pending, out_ready low 5 cycles -> out_valid=1, out_gcd=6 stable, in_ready=0, in_valid pulses ignored; handshake on cycle 6 -> IDLE.
REQ-030 GCD_TIMEOUT_EN, TIMEOUT=16, engine never asserts done -> out_valid after 16 WAIT cycles, out_gcd=0, out_err=1.
REQ-031 rst_n low during WAIT of (48,18) -> all outputs 0 immediately; after release, (35,21) with result 7 -> out_gcd=7.
